priority_irq_ctrl: RTL



---
 rtl/priority_irq_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl
// Registered, parametrised priority interrupt controller. Request lines are
// latched into a pending register, then qualified by a per-line enable mask.
// One winning index is presented with a valid/ack handshake.
// Priority is either fixed (highest index wins) or round-robin (descending
// search starting at a rotating pointer).
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous, active-high reset
//   req      - N request lines; a 1 sets the matching pending bit
//   mask     - N enables; 1 = eligible for grant, 0 = held pending only
//   ack      - consumer accepts the current grant
//   y        - granted index (registered)
//   valid    - y is a live grant (registered)
//   pending  - pending register (registered)
module priority_irq_ctrl #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic [W-1:0] rr;
  logic         take;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] sel;
  logic         any;

  // Handshake decode: a grant is consumed only when it is live and acked.
  // The consumed line is removed from the candidate set so that the next
  // grant can be chosen in the same cycle, giving one grant per clock.
  always_comb begin
    take = valid & ack;
    clr  = '0;
    if (take) begin
      clr[y] = 1'b1;
    end
    cand = pending & mask & ~clr;
    any  = |cand;
  end

  // Winner selection over the candidate set. Fixed mode lets the highest
  // index overwrite lower ones. Round-robin walks the indices from furthest
  // to nearest in the descending order rr, rr-1, ... with wrap, so the entry
  // at rr itself is written last and therefore has top priority. The wrap is
  // done by explicit addition so that non-power-of-2 N also works.
  always_comb begin
    int           t;
    logic [W-1:0] ix;
    sel = '0;
    t   = 0;
    ix  = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          sel = W'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        t = int'(rr) - k;
        if (t < 0) begin
          t = t + N;
        end
        ix = W'(t);
        if (cand[ix]) begin
          sel = ix;
        end
      end
    end
  end

  // State registers. A live grant that has not been acked is frozen so the
  // consumer never sees it revoked. Otherwise the output register reloads
  // from the current selection. Requests re-set pending bits after the
  // clear, so a line that requests again while being acked stays pending.
  // The round-robin pointer moves only when a grant is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      valid   <= 1'b0;
      y       <= '0;
      rr      <= W'(N - 1);
    end else begin
      pending <= (pending & ~clr) | req;
      if (!(valid && !ack)) begin
        valid <= any;
        y     <= any ? sel : '0;
      end
      if (take) begin
        rr <= (y == '0) ? W'(N - 1) : (y - W'(1));
      end
    end
  end

endmodule
